// File: rtl/if_id_fetch_pkg.sv
// if_id_fetch_pkg: shared pipeline types, constants and field helpers for the fetch stage.
package if_id_fetch_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  function automatic logic [4:0] rs1_of(input logic [31:0] instr);
    return instr[RS1_LSB +: 5];
  endfunction

  function automatic logic [4:0] rs2_of(input logic [31:0] instr);
    return instr[RS2_LSB +: 5];
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_fetch_if.sv
// if_id_fetch_if: hazard-unit, instruction-memory and IF/ID signals of the fetch stage.
interface if_id_fetch_if;
  logic        PC_write;
  logic        IFID_Write;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] IFID_pc;
  logic [31:0] IFID_instr;
  logic        IFID_valid;
  logic [4:0]  IFID_rs1;
  logic [4:0]  IFID_rs2;

  modport master (
    input  PC_write, IFID_Write, branch_taken, branch_target,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr,
    output IFID_pc, IFID_instr, IFID_valid, IFID_rs1, IFID_rs2
  );

  modport slave (
    output PC_write, IFID_Write, branch_taken, branch_target,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr,
    input  IFID_pc, IFID_instr, IFID_valid, IFID_rs1, IFID_rs2
  );
endinterface

// File: rtl/if_id_fetch_fetch_ctrl.sv
// fetch_ctrl: fetch FSM, PC and hold buffer; keeps at most one memory request in flight.
module fetch_ctrl
  import if_id_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  output logic        load_o,
  output logic [31:0] load_pc_o,
  output logic [31:0] load_instr_o
);
  fetch_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, inflight_q, inflight_d, hold_q, hold_d;
  logic drop_q, drop_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      hold_q     <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      hold_q     <= hold_d;
      drop_q     <= drop_d;
    end
  end

  assign imem_req_o  = state_q == REQ;
  assign imem_addr_o = pc_q;
  assign load_pc_o   = inflight_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inflight_d   = inflight_q;
    hold_d       = hold_q;
    drop_d       = drop_q;
    load_o       = 1'b0;
    load_instr_o = imem_rdata_i;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: if (imem_gnt_i) begin
        inflight_d = pc_q;
        state_d    = WAIT;
      end
      WAIT: if (imem_rvalid_i) begin
        state_d = REQ;
        if (drop_q) drop_d = 1'b0;
        else if (advance_i) load_o = 1'b1;
        else begin
          hold_d  = imem_rdata_i;
          state_d = HOLD;
        end
      end
      HOLD: if (advance_i) begin
        load_o       = 1'b1;
        load_instr_o = hold_q;
        state_d      = REQ;
      end
    endcase
    if (load_o) pc_d = next_pc(pc_q);
    // A redirect must still drain a response it cannot cancel, so it waits with drop set.
    if (branch_taken_i) begin
      load_o  = 1'b0;
      pc_d    = {branch_target_i[31:2], 2'b00};
      drop_d  = (state_q == REQ && imem_gnt_i) || (state_q == WAIT && !imem_rvalid_i);
      state_d = drop_d ? WAIT : REQ;
    end
  end
endmodule

// File: rtl/if_id_fetch.sv
// if_id_fetch: instruction fetch stage with IF/ID pipeline register.
module if_id_fetch
  import if_id_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input logic          clk,
  input logic          rst_n,
  if_id_fetch_if.master bus
);
  logic        load;
  logic [31:0] load_pc, load_instr;
  logic [31:0] pc_q, pc_d, instr_q, instr_d;
  logic        valid_q, valid_d;

  fetch_ctrl #(.RESET_PC(RESET_PC)) u_ctrl (
    .clk            (clk),
    .rst_n          (rst_n),
    .advance_i      (bus.PC_write & bus.IFID_Write),
    .branch_taken_i (bus.branch_taken),
    .branch_target_i(bus.branch_target),
    .imem_gnt_i     (bus.imem_gnt),
    .imem_rvalid_i  (bus.imem_rvalid),
    .imem_rdata_i   (bus.imem_rdata),
    .imem_req_o     (bus.imem_req),
    .imem_addr_o    (bus.imem_addr),
    .load_o         (load),
    .load_pc_o      (load_pc),
    .load_instr_o   (load_instr)
  );

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (bus.branch_taken || (bus.IFID_Write && !load)) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (load) begin
      pc_d    = load_pc;
      instr_d = load_instr;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign bus.IFID_pc    = pc_q;
  assign bus.IFID_instr = instr_q;
  assign bus.IFID_valid = valid_q;
  assign bus.IFID_rs1   = rs1_of(instr_q);
  assign bus.IFID_rs2   = rs2_of(instr_q);
endmodule

// File: tb/tb_if_id_fetch.sv
// tb_if_id_fetch: directed and random stimulus checked against a transaction-level fetch model.
module tb_if_id_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_id_fetch_if bus ();
  if_id_fetch #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int tests = 0;
  int fails = 0;

  // Model: next fetch address, one outstanding transaction, one parked word, expected IF/ID.
  bit          m_gap, m_out, m_stale, m_pend;
  logic [31:0] m_pc, m_out_pc, m_pend_pc, m_pend_w;
  logic [31:0] e_pc, e_instr;
  bit          e_valid;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_gap = 1; m_out = 0; m_stale = 0; m_pend = 0; m_pc = RST_PC;
    m_out_pc = '0; m_pend_pc = '0; m_pend_w = '0;
    e_pc = '0; e_instr = NOP; e_valid = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_IFID_pc"}, bus.IFID_pc, e_pc);
    chk({tag, "_IFID_instr"}, bus.IFID_instr, e_instr);
    chk({tag, "_IFID_valid"}, {31'b0, bus.IFID_valid}, {31'b0, e_valid});
    chk({tag, "_rs1"}, {27'b0, bus.IFID_rs1}, {27'b0, e_instr[19:15]});
    chk({tag, "_rs2"}, {27'b0, bus.IFID_rs2}, {27'b0, e_instr[24:20]});
  endtask

  task automatic cyc(input bit pw, input bit iw, input bit br, input logic [31:0] tgt,
                     input bit gnt, input bit rv);
    bit req_e, adv, ld;
    logic [31:0] rd, lpc, lw;
    rd = (rv && m_out) ? memw(m_out_pc) : $urandom;
    bus.PC_write = pw; bus.IFID_Write = iw; bus.branch_taken = br; bus.branch_target = tgt;
    bus.imem_gnt = gnt; bus.imem_rvalid = rv; bus.imem_rdata = rd;
    req_e = !m_gap && !m_out && !m_pend;
    #1;
    chk("imem_req", {31'b0, bus.imem_req}, {31'b0, req_e});
    if (req_e) chk("imem_addr", bus.imem_addr, m_pc);
    check_regs("cyc");
    @(posedge clk);
    adv = pw && iw; ld = 0; lpc = '0; lw = '0;
    if (rv && m_out) begin
      m_out = 0;
      if (!m_stale && !br) begin
        if (adv) begin ld = 1; lpc = m_out_pc; lw = rd; end
        else begin m_pend = 1; m_pend_pc = m_out_pc; m_pend_w = rd; end
      end
    end else if (m_pend && adv && !br) begin
      ld = 1; lpc = m_pend_pc; lw = m_pend_w; m_pend = 0;
    end
    if (ld) m_pc = m_pc + 32'd4;
    if (req_e && gnt) begin m_out = 1; m_out_pc = m_pc; m_stale = 0; end
    if (br) begin
      m_pc = tgt & 32'hFFFF_FFFC;
      m_pend = 0;
      if (m_out) m_stale = 1;
    end
    m_gap = 0;
    if (br || (iw && !ld)) begin e_instr = NOP; e_valid = 0; end
    else if (ld) begin e_pc = lpc; e_instr = lw; e_valid = 1; end
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.branch_taken = 0;
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("rst_imem_req", {31'b0, bus.imem_req}, 32'h0);
    check_regs("rst");
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic to_wait();
    for (int i = 0; i < 8 && !m_out; i++) cyc(1, 1, 0, '0, 1, 0);
  endtask

  initial begin
    bus.PC_write = 0; bus.IFID_Write = 0; bus.branch_taken = 0; bus.branch_target = '0;
    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = '0;
    model_reset();
    @(negedge clk);
    do_reset();
    // Back-to-back fetches: one instruction per two cycles.
    repeat (7) cyc(1, 1, 0, '0, 1, 1);
    #1 chk("seq_pc", bus.IFID_pc, 32'h0000_0008);
    chk("seq_valid", {31'b0, bus.IFID_valid}, 32'h1);
    // Response arrives under a full stall and is parked.
    to_wait();
    cyc(0, 0, 0, '0, 0, 1);
    cyc(0, 0, 0, '0, 1, 0);
    cyc(0, 0, 0, '0, 1, 1);
    cyc(1, 1, 0, '0, 1, 0);
    repeat (3) cyc(1, 1, 0, '0, 1, 1);
    // Redirect while a response is outstanding; the stale word is dropped.
    to_wait();
    cyc(1, 1, 1, 32'h0000_0103, 0, 0);
    cyc(1, 1, 0, '0, 0, 1);
    #1 chk("br_addr", bus.imem_addr, 32'h0000_0100);
    chk("br_instr", bus.IFID_instr, NOP);
    chk("br_valid", {31'b0, bus.IFID_valid}, 32'h0);
    repeat (4) cyc(1, 1, 0, '0, 1, 1);
    // Redirect beats a stall on the IF/ID register.
    to_wait();
    cyc(1, 0, 1, 32'h0000_0200, 0, 1);
    repeat (4) cyc(1, 1, 0, '0, 1, 1);
    // PC wrap at the top of the address space.
    cyc(1, 1, 1, 32'hFFFF_FFFC, 0, 0);
    repeat (2) cyc(1, 1, 0, '0, 1, 1);
    #1 chk("wrap_addr", bus.imem_addr, 32'h0000_0000);
    chk("wrap_pc", bus.IFID_pc, 32'hFFFF_FFFC);
    repeat (2) cyc(1, 1, 0, '0, 1, 1);
    // Reset mid-transaction followed by a late response.
    to_wait();
    do_reset();
    cyc(1, 1, 0, '0, 0, 1);
    cyc(1, 1, 0, '0, 0, 1);
    #1 chk("rst_first_addr", bus.imem_addr, RST_PC);
    repeat (4) cyc(1, 1, 0, '0, 1, 1);
    // Randomized traffic.
    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 19) == 0,
          $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
